ahblite_slave_mux: RTL and testbench

AHB-Lite response-side interconnect that closes the loop on the address decoder. It takes the per-port select vector produced during the address phase and registers it into the data phase. It then steers the selected slave's HREADYOUT/HRDATA/HRESP back to the Cortex-M0 master. It also contains a built-in default slave: any active transfer that no enabled port claims gets a two-cycle AHB ERROR response, and the block records the faulting address and a saturating fault count.

---
 rtl/ahblite_slave_mux.sv | 102 ++++++++++
 tb/tb_ahblite_slave_mux.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite response mux with a built-in default slave.
// Registers the decoder select into the data phase and records unmapped-transfer faults.
module ahblite_slave_mux #(
    parameter logic [11:0] PORT_EN   = 12'hFFF,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [31:0]          HADDR,
    input  logic [1:0]           HTRANS,
    input  logic [11:0]          P_HSEL,
    input  logic [11:0]          P_HREADYOUT,
    input  logic [11:0]          P_HRESP,
    input  logic [383:0]         P_HRDATA,
    output logic                 HREADY,
    output logic                 HRESP,
    output logic [31:0]          HRDATA,
    output logic [31:0]          FAULT_ADDR,
    output logic [ERR_CNT_W-1:0] FAULT_CNT
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ERR1 = 2'd1;
    localparam logic [1:0] ST_ERR2 = 2'd2;

    logic [11:0]          sel_en;
    logic [11:0]          sel_pri;
    logic [11:0]          dsel_q, dsel_d;
    logic [1:0]           state_q, state_d;
    logic [1:0]           state_smp;
    logic [31:0]          fault_addr_q, fault_addr_d;
    logic [ERR_CNT_W-1:0] fault_cnt_q, fault_cnt_d;

    assign sel_en  = P_HSEL & PORT_EN;
    // Isolate the lowest set bit so the data-phase select is one-hot by priority.
    assign sel_pri = sel_en & (~sel_en + 12'd1);

    always_comb begin
        dsel_d       = dsel_q;
        fault_addr_d = fault_addr_q;
        fault_cnt_d  = fault_cnt_q;
        state_smp    = ST_IDLE;
        if (HREADY) begin
            if (!HTRANS[1]) begin
                dsel_d = '0;
            end else if (sel_en == 12'd0) begin
                dsel_d       = '0;
                state_smp    = ST_ERR1;
                fault_addr_d = HADDR;
                if (fault_cnt_q != {ERR_CNT_W{1'b1}}) begin
                    fault_cnt_d = fault_cnt_q + ERR_CNT_W'(1);
                end
            end else begin
                dsel_d = sel_pri;
            end
        end

        case (state_q)
            ST_ERR1:          state_d = ST_ERR2;
            ST_IDLE, ST_ERR2: state_d = HREADY ? state_smp : state_q;
            default:          state_d = HREADY ? state_smp : ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dsel_q       <= '0;
            state_q      <= ST_IDLE;
            fault_addr_q <= '0;
            fault_cnt_q  <= '0;
        end else begin
            dsel_q       <= dsel_d;
            state_q      <= state_d;
            fault_addr_q <= fault_addr_d;
            fault_cnt_q  <= fault_cnt_d;
        end
    end

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        if (state_q == ST_ERR1) begin
            HREADY = 1'b0;
            HRESP  = 1'b1;
        end else if (state_q == ST_ERR2) begin
            HRESP = 1'b1;
        end else begin
            for (int i = 0; i < 12; i++) begin
                if (dsel_q[i]) begin
                    HREADY = P_HREADYOUT[i];
                    HRESP  = P_HRESP[i];
                    HRDATA = P_HRDATA[32*i +: 32];
                end
            end
        end
    end

    assign FAULT_ADDR = fault_addr_q;
    assign FAULT_CNT  = fault_cnt_q;

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Scoreboard bench: the driver queues the expected data-phase response of each cycle,
// a negedge monitor pops and compares it against the DUT.
module tb_ahblite_slave_mux;

    logic         HCLK;
    logic         HRESETn;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic [11:0]  P_HSEL;
    logic [11:0]  P_HREADYOUT;
    logic [11:0]  P_HRESP;
    logic [383:0] P_HRDATA;
    logic         HREADY;
    logic         HRESP;
    logic [31:0]  HRDATA;
    logic [31:0]  FAULT_ADDR;
    logic [7:0]   FAULT_CNT;

    // Port 0 disabled so the masking case is covered by the same instance.
    ahblite_slave_mux #(
        .PORT_EN   (12'hFFE),
        .ERR_CNT_W (8)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .P_HSEL      (P_HSEL),
        .P_HREADYOUT (P_HREADYOUT),
        .P_HRESP     (P_HRESP),
        .P_HRDATA    (P_HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA),
        .FAULT_ADDR  (FAULT_ADDR),
        .FAULT_CNT   (FAULT_CNT)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic        rdy;
        logic        resp;
        logic [31:0] data;
        logic [31:0] fa;
        logic [7:0]  fc;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] ef_addr;
    logic [7:0]  ef_cnt;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;

    always @(negedge HCLK) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (HREADY !== e.rdy || HRESP !== e.resp || HRDATA !== e.data) begin
                bad++;
                $display("FAIL bus t=%0t: got rdy=%b resp=%b data=%h, want rdy=%b resp=%b data=%h",
                         $time, HREADY, HRESP, HRDATA, e.rdy, e.resp, e.data);
            end
            total++;
            if (FAULT_ADDR !== e.fa || FAULT_CNT !== e.fc) begin
                bad++;
                $display("FAIL fault t=%0t: got addr=%h cnt=%0d, want addr=%h cnt=%0d",
                         $time, FAULT_ADDR, FAULT_CNT, e.fa, e.fc);
            end
        end
    end

    // Drive one cycle: address phase for the next transfer, slave responses for the
    // current data phase, and the hand-computed response expected in this cycle.
    task automatic cyc(input logic [1:0] tr, input logic [31:0] a, input logic [11:0] sel,
                       input logic [11:0] ro, input logic [11:0] rs,
                       input logic er, input logic ep, input logic [31:0] ed);
        exp_t e;
        HTRANS      = tr;
        HADDR       = a;
        P_HSEL      = sel;
        P_HREADYOUT = ro;
        P_HRESP     = rs;
        e.rdy  = er;
        e.resp = ep;
        e.data = ed;
        e.fa   = ef_addr;
        e.fc   = ef_cnt;
        exp_q.push_back(e);
        @(posedge HCLK);
        #1;
    endtask

    task automatic fault(input logic [31:0] a);
        ef_addr = a;
        if (ef_cnt != 8'hFF) ef_cnt = ef_cnt + 8'd1;
    endtask

    initial begin
        HRESETn     = 1'b0;
        HTRANS      = IDLE;
        HADDR       = '0;
        P_HSEL      = '0;
        P_HREADYOUT = '1;
        P_HRESP     = '0;
        for (int i = 0; i < 12; i++) P_HRDATA[32*i +: 32] = 32'hA000_0000 + i;
        P_HRDATA[64 +: 32] = 32'hDEAD_BEEF;
        ef_addr = '0;
        ef_cnt  = '0;
        @(posedge HCLK);
        #1;

        // Reset state
        cyc(IDLE, 32'h0, 12'h000, 12'hFFF, 12'h000, 1'b1, 1'b0, 32'h0);
        HRESETn = 1'b1;

        // Zero-wait read from port 2
        cyc(NONSEQ, 32'h2000_0000, 12'h004, 12'hFFF, 12'h000, 1'b1, 1'b0, 32'h0);
        cyc(IDLE, 32'h0, 12'h000, 12'hFFF, 12'h000, 1'b1, 1'b0, 32'hDEAD_BEEF);

        // Port 3 with 3 wait states; select changes and foreign responses are ignored
        cyc(NONSEQ, 32'h3000_0000, 12'h008, 12'hFFF, 12'h000, 1'b1, 1'b0, 32'h0);
        cyc(NONSEQ, 32'h4000_0000, 12'h040, 12'hFF7, 12'hFF7, 1'b0, 1'b0, 32'hA000_0003);
        cyc(NONSEQ, 32'h4000_0000, 12'h040, 12'hFF7, 12'hFF7, 1'b0, 1'b0, 32'hA000_0003);
        cyc(NONSEQ, 32'h4000_0000, 12'h040, 12'hFF7, 12'hFF7, 1'b0, 1'b0, 32'hA000_0003);
        cyc(IDLE, 32'h0, 12'h000, 12'h008, 12'hFF7, 1'b1, 1'b0, 32'hA000_0003);

        // Single unmapped transfer
        cyc(NONSEQ, 32'h5000_0010, 12'h000, 12'hFFF, 12'h000, 1'b1, 1'b0, 32'h0);
        fault(32'h5000_0010);
        cyc(IDLE, 32'h0, 12'h000, 12'hFFF, 12'h000, 1'b0, 1'b1, 32'h0);
        cyc(IDLE, 32'h0, 12'h000, 12'hFFF, 12'h000, 1'b1, 1'b1, 32'h0);
        cyc(IDLE, 32'h0, 12'h000, 12'hFFF, 12'h000, 1'b1, 1'b0, 32'h0);

        // Back-to-back unmapped transfers
        cyc(NONSEQ, 32'h5000_0020, 12'h000, 12'hFFF, 12'h000, 1'b1, 1'b0, 32'h0);
        fault(32'h5000_0020);
        cyc(NONSEQ, 32'h5000_0030, 12'h000, 12'hFFF, 12'h000, 1'b0, 1'b1, 32'h0);
        cyc(NONSEQ, 32'h5000_0030, 12'h000, 12'hFFF, 12'h000, 1'b1, 1'b1, 32'h0);
        fault(32'h5000_0030);
        cyc(IDLE, 32'h0, 12'h000, 12'hFFF, 12'h000, 1'b0, 1'b1, 32'h0);
        cyc(IDLE, 32'h0, 12'h000, 12'hFFF, 12'h000, 1'b1, 1'b1, 32'h0);

        // Disabled port 0 faults; mapped transfer taken in ERR2; priority picks port 6
        cyc(NONSEQ, 32'h0000_0100, 12'h001, 12'hFFF, 12'h000, 1'b1, 1'b0, 32'h0);
        fault(32'h0000_0100);
        cyc(NONSEQ, 32'h6000_0000, 12'h0C0, 12'hFFF, 12'h000, 1'b0, 1'b1, 32'h0);
        cyc(NONSEQ, 32'h6000_0000, 12'h0C0, 12'hFFF, 12'h000, 1'b1, 1'b1, 32'h0);
        cyc(IDLE, 32'h0, 12'h000, 12'hFFF, 12'h080, 1'b1, 1'b0, 32'hA000_0006);
        cyc(IDLE, 32'h0, 12'h000, 12'hFFF, 12'h000, 1'b1, 1'b0, 32'h0);

        // 300 consecutive faults saturate the counter
        cyc(NONSEQ, 32'h7000_0000, 12'h000, 12'hFFF, 12'h000, 1'b1, 1'b0, 32'h0);
        fault(32'h7000_0000);
        for (int i = 1; i < 300; i++) begin
            cyc(NONSEQ, 32'h7000_0000 + i, 12'h000, 12'hFFF, 12'h000, 1'b0, 1'b1, 32'h0);
            cyc(NONSEQ, 32'h7000_0000 + i, 12'h000, 12'hFFF, 12'h000, 1'b1, 1'b1, 32'h0);
            fault(32'h7000_0000 + i);
        end
        cyc(IDLE, 32'h0, 12'h000, 12'hFFF, 12'h000, 1'b0, 1'b1, 32'h0);
        cyc(IDLE, 32'h0, 12'h000, 12'hFFF, 12'h000, 1'b1, 1'b1, 32'h0);
        cyc(IDLE, 32'h0, 12'h000, 12'hFFF, 12'h000, 1'b1, 1'b0, 32'h0);

        // Reset asserted during ERR1
        cyc(NONSEQ, 32'h5000_0040, 12'h000, 12'hFFF, 12'h000, 1'b1, 1'b0, 32'h0);
        fault(32'h5000_0040);
        HRESETn = 1'b0;
        cyc(IDLE, 32'h0, 12'h000, 12'hFFF, 12'h000, 1'b0, 1'b1, 32'h0);
        HRESETn = 1'b1;
        ef_addr = '0;
        ef_cnt  = '0;
        cyc(IDLE, 32'h0, 12'h000, 12'hFFF, 12'h000, 1'b1, 1'b0, 32'h0);
        cyc(NONSEQ, 32'h2000_0004, 12'h004, 12'hFFF, 12'h000, 1'b1, 1'b0, 32'h0);
        cyc(IDLE, 32'h0, 12'h000, 12'hFFF, 12'h000, 1'b1, 1'b0, 32'hDEAD_BEEF);

        #10;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
